// File: rtl/llr_loader.sv
// Frame loader: saturates channel LLRs to Q bits, packs B-LLR beats into
// P-LLR words and writes one word to the alpha storage every P/B beats.
module llr_loader #(
    parameter int Q = 6,
    parameter int W = 8,
    parameter int P = 128,
    parameter int B = 16,
    parameter int N = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B*W-1:0]   in_data,
    output logic [P*Q-1:0]   a_in,
    output logic [4:0]       layer_w,
    output logic [4:0]       cnta,
    output logic             w_en,
    output logic             busy,
    output logic             done,
    output logic [10:0]      sat_cnt,
    output logic [1:0]       dbg_state
);
    localparam int BEATS = N / B;
    localparam int BW    = $clog2(BEATS);
    localparam int WB    = P / B;
    localparam int WBW   = $clog2(WB);
    localparam int CW    = $clog2(B + 1);
    localparam int LIM   = 2 ** (Q - 1) - 1;

    localparam logic signed [W-1:0] POS_W = W'(LIM);
    localparam logic signed [W-1:0] NEG_W = W'(-LIM);
    localparam logic [Q-1:0]        POS_Q = Q'(LIM);
    localparam logic [Q-1:0]        NEG_Q = Q'(-LIM);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready is high for the whole LOAD state and depends on nothing else.
    state_t           state;
    logic [BW-1:0]    beat_cnt;
    logic [P*Q-1:0]   pack;
    logic [P*Q-1:0]   word_next;
    logic [CW-1:0]    clip_cnt;
    logic [WBW-1:0]   slot;
    logic             accept;

    assign slot      = beat_cnt[WBW-1:0];
    assign in_ready  = (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign layer_w   = w_en ? 5'd10 : 5'd0;
    assign dbg_state = state;

    // The current beat is merged into the packing word; -2^(Q-1) is never produced.
    always_comb begin
        word_next = pack;
        clip_cnt  = '0;
        for (int j = 0; j < B; j++) begin
            if ($signed(in_data[j*W +: W]) > POS_W) begin
                word_next[(int'(slot)*B + j)*Q +: Q] = POS_Q;
                clip_cnt = clip_cnt + CW'(1);
            end else if ($signed(in_data[j*W +: W]) < NEG_W) begin
                word_next[(int'(slot)*B + j)*Q +: Q] = NEG_Q;
                clip_cnt = clip_cnt + CW'(1);
            end else begin
                word_next[(int'(slot)*B + j)*Q +: Q] = in_data[j*W +: Q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            pack     <= '0;
            a_in     <= '0;
            cnta     <= '0;
            w_en     <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            w_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        beat_cnt <= '0;
                        sat_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pack     <= word_next;
                        beat_cnt <= beat_cnt + BW'(1);
                        sat_cnt  <= sat_cnt + 11'(clip_cnt);
                        // a_in is taken from word_next so the packer can refill at once.
                        if (slot == WBW'(WB - 1)) begin
                            a_in <= word_next;
                            cnta <= 5'(beat_cnt >> WBW);
                            w_en <= 1'b1;
                        end
                        if (beat_cnt == BW'(BEATS - 1)) state <= DRAIN;
                    end
                end
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_llr_loader.sv
// Randomized scoreboard bench for llr_loader: the driver pushes expected
// storage words, a monitor pops them on every w_en and compares.
module tb_llr_loader;
    localparam int Q = 6;
    localparam int W = 8;
    localparam int P = 128;
    localparam int B = 16;
    localparam int N = 1024;
    localparam int XW = P*Q + 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [B*W-1:0]   in_data = '0;
    logic [P*Q-1:0]   a_in;
    logic [4:0]       layer_w;
    logic [4:0]       cnta;
    logic             w_en;
    logic             busy;
    logic             done;
    logic [10:0]      sat_cnt;
    logic [1:0]       dbg_state;

    llr_loader #(.Q(Q), .W(W), .P(P), .B(B), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .a_in(a_in),
        .layer_w(layer_w), .cnta(cnta), .w_en(w_en), .busy(busy),
        .done(done), .sat_cnt(sat_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count / watchdog ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    int llr_mem[N];
    logic [XW-1:0] exp_q[$];
    int exp_gap = 8;
    int done_seen = 0;
    int last_wen = 0;

    function automatic int sat_ref(input int x);
        if (x > 31) return 31;
        if (x < -31) return -31;
        return x;
    endfunction

    // Word w of a frame is simply LLRs w*P .. w*P+P-1 in order, saturated.
    task automatic push_word(input int wi);
        logic [P*Q-1:0] w;
        for (int i = 0; i < P; i++) w[i*Q +: Q] = Q'(sat_ref(llr_mem[wi*P + i]));
        exp_q.push_back({5'(wi), w});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: cnta %0d with empty expected queue", cnta);
                end else begin
                    logic [XW-1:0] e;
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({cnta, a_in} == e) n_pass++;
                    else $display("FAIL write: got cnta=%0d a_in=%h expected cnta=%0d a_in=%h",
                                  cnta, a_in, e[XW-1 -: 5], e[P*Q-1:0]);
                end
                chk("layer_w_on_write", layer_w, 10);
                if (cnta != 0) chk("write_interval", cyc - last_wen, exp_gap);
                last_wen = cyc;
            end else if (layer_w != 0) begin
                chk("layer_w_idle", layer_w, 0);
            end
            if (done) done_seen++;
        end
    end

    // ---------------- driver ----------------
    task automatic load_frame(input bit gap, input int nbeats, input bit start_load, input bit start_done);
        int exp_sat;
        int n;
        bit acc;
        logic [B*W-1:0] d;
        exp_sat = 0;
        exp_gap = gap ? 16 : 8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int j = 0; j < B; j++) begin
                d[j*W +: W] = W'(llr_mem[b*B + j]);
                if (sat_ref(llr_mem[b*B + j]) != llr_mem[b*B + j]) exp_sat++;
            end
            in_data  = d;
            in_valid = 1'b1;
            start    = start_load && (b == 10);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 8) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                n++;
            end
            start    = 1'b0;
            in_valid = 1'b0;
            chk("beat_accept", acc, 1);
            if (b % 8 == 7) push_word(b / 8);
            if (gap && b != nbeats - 1) begin
                @(posedge clk); #1;
            end
        end
        if (nbeats < N / B) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        chk("done_latency", n, 2);
        chk("busy_in_done", busy, 1);
        chk("in_ready_in_done", in_ready, 0);
        chk("sat_cnt", sat_cnt, exp_sat);
        if (start_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (start_done) begin
            @(negedge clk);
            chk("start_in_done_ignored", busy, 0);
            chk("sat_cnt_hold", sat_cnt, exp_sat);
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) llr_mem[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_in"}, (a_in == '0) ? 1 : 0, 1);
        chk({tag, "_cnta"}, cnta, 0);
        chk({tag, "_layer_w"}, layer_w, 0);
        chk({tag, "_w_en"}, w_en, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat_cnt"}, sat_cnt, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // ramp frame
        for (int k = 0; k < N; k++) llr_mem[k] = k % 32;
        load_frame(1'b0, 64, 1'b0, 1'b0);

        // saturation frame
        for (int k = 0; k < N; k++) llr_mem[k] = (k < 16) ? 100 : ((k < 32) ? -128 : -31);
        load_frame(1'b0, 64, 1'b0, 1'b0);

        // backpressure: in_valid toggles 1,0
        fill_random();
        load_frame(1'b1, 64, 1'b0, 1'b0);

        // start pulsed during LOAD and during DONE
        fill_random();
        load_frame(1'b0, 64, 1'b1, 1'b1);

        // reset after 20 beats, then a clean frame
        fill_random();
        load_frame(1'b0, 20, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midframe_reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abandoned_writes_left", exp_q.size(), 0);
        fill_random();
        load_frame(1'b0, 64, 1'b0, 1'b0);

        // back-to-back frames, second start the cycle after done
        fill_random();
        load_frame(1'b0, 64, 1'b0, 1'b0);
        fill_random();
        load_frame(1'b0, 64, 1'b0, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        chk("pending_writes", exp_q.size(), 0);
        chk("done_pulses", done_seen, 7);
        chk("final_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/llr_loader.md
LLR_LOADER -- requirements
Module: llr_loader

Interface
REQ-001 SHALL have parameter Q, default 6, meaning stored LLR width in bits.
REQ-002 SHALL have parameter W, default 8, meaning channel LLR input width in bits (signed two's complement).
REQ-003 SHALL have parameter P, default 128, meaning LLRs per storage write word.
REQ-004 SHALL have parameter B, default 16, meaning LLRs per input beat.
REQ-005 SHALL have parameter N, default 1024, meaning LLRs per frame.
REQ-006 SHALL have port clk, input, 1, meaning system clock, rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-008 SHALL have port start, input, 1, meaning one-cycle pulse that begins frame load.
REQ-009 SHALL have port in_valid, input, 1, meaning in_data carries a beat.
REQ-010 SHALL have port in_ready, output, 1, meaning loader accepts a beat this cycle.
REQ-011 SHALL have port in_data, input, B*W, meaning B LLRs; LLR j sits in bits [(j+1)*W-1 : j*W].
REQ-012 SHALL have port a_in, output, P*Q, meaning packed saturated word to the alpha storage.
REQ-013 SHALL have port layer_w, output, 5, meaning storage write layer.
REQ-014 SHALL have port cnta, output, 5, meaning storage write word index.
REQ-015 SHALL have port w_en, output, 1, meaning storage write strobe.
REQ-016 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-017 SHALL have port done, output, 1, meaning one-cycle frame-complete pulse.
REQ-018 SHALL have port sat_cnt, output, 11, meaning count of LLRs clipped in the current or last frame.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on start; LOAD->DRAIN on acceptance of beat N/B-1 (63); DRAIN->DONE unconditionally; DONE->IDLE unconditionally.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL drive in_ready=1 only in LOAD; a beat is accepted when in_valid && in_ready.
REQ-022 SHALL keep a 6-bit beat counter, cleared on IDLE->LOAD and incremented per accepted beat; in_valid low stalls with no state change.
REQ-023 SHALL saturate each LLR to [-(2^(Q-1)-1), +(2^(Q-1)-1)] = [-31, +31]; -32 is never produced.
REQ-024 SHALL pass in-range LLRs unchanged, sign-extended/truncated to Q bits.
REQ-025 SHALL place LLR j of beat b (b = beat_cnt[2:0]) at packing bits [(16*b+j+1)*Q-1 : (16*b+j)*Q].
REQ-026 SHALL, on acceptance of the 8th beat of a word (beat_cnt[2:0]=7), load the completed word including that beat into a_in and assert w_en the next cycle.
REQ-027 SHALL drive cnta = beat_cnt[5:3] of the completing beat (0..7), held with a_in until the next write.
REQ-028 SHALL keep w_en high for exactly one cycle per word: 8 pulses per frame, cnta 0,1,...,7 in order.
REQ-029 SHALL sustain one beat per cycle with no bubble at word boundaries; the packing register refills while a_in holds the previous word.
REQ-030 SHALL drive layer_w=10 while w_en=1 and 0 otherwise.
REQ-031 SHALL issue the final write (cnta=7) in DRAIN with in_ready=0, assert done=1 in DONE only, and clear busy in IDLE.
REQ-032 SHALL clear sat_cnt on IDLE->LOAD, add the number of clipped LLRs per accepted beat (0..16), and hold the value through IDLE until the next start.
REQ-033 SHALL give a frame latency of 64 accepted beats + 2 cycles from the first accepted beat to done, with no stalls.

Reset
REQ-034 SHALL, with rst=1 at a rising edge, force IDLE, beat counter 0, a_in=0, cnta=0, layer_w=0, w_en=0, in_ready=0, busy=0, done=0, sat_cnt=0.
REQ-035 SHALL abandon a partial frame on rst mid-LOAD: no further w_en, and no done for that frame.
REQ-036 SHALL give rst priority over start in the same cycle.

Verification
REQ-037 SHALL test a ramp frame: LLR k = k mod 32, valid always high -> 8 w_en pulses at consecutive 8-cycle intervals, cnta 0..7, a_in slice k = k mod 32, done 2 cycles after beat 63, sat_cnt=0.
REQ-038 SHALL test saturation: all LLRs +100 in beat 0, -128 in beat 1, -31 elsewhere -> slices +31/-31/-31, sat_cnt=32.
REQ-039 SHALL test backpressure: in_valid toggling 1,0 -> beat count and packing unaffected, w_en every 16 cycles, data identical to the no-gap run.
REQ-040 SHALL test start pulsed during LOAD and during DONE -> ignored; no beat-counter reset; exactly 8 writes.
REQ-041 SHALL test rst after 20 beats -> all outputs 0 next cycle; a new start then loads a full frame correctly with cnta starting at 0.
REQ-042 SHALL test back-to-back frames, start the cycle after done -> second frame writes cnta 0..7 again and sat_cnt restarts from 0.
